// File: rtl/sequential_multiplier_integrated.sv
// Radix-2 shift-add multiplier: N-cycle iterative product with start/busy/done
// handshake, signed/unsigned mode, and a registered 2N-bit result.
//   state | meaning
//   IDLE  | waiting for start; product holds last result
//   RUN   | one partial-product add per cycle, counter 0..N-1
module sequential_multiplier_integrated #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signedMode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           accessError
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] acc_sum;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           accept;

  assign accept  = (state == IDLE) && start;
  assign last    = (cnt == LAST);
  assign addend  = {{N{1'b0}}, mcand} << cnt;
  assign acc_sum = mplier[0] ? (acc + addend) : acc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Operands are stored as magnitudes; the sign is reapplied once at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      product     <= '0;
      done        <= 1'b0;
      accessError <= 1'b0;
    end else begin
      done        <= 1'b0;
      accessError <= start && (state == RUN);
      if (accept) begin
        mcand  <= (signedMode && a[N-1]) ? -a : a;
        mplier <= (signedMode && b[N-1]) ? -b : b;
        neg    <= signedMode && (a[N-1] ^ b[N-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) begin
          product <= neg ? -acc_sum : acc_sum;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_multiplier_integrated.sv
// Self-checking bench for sequential_multiplier_integrated at N=8: directed
// corners plus randomized operands against an integer-arithmetic model.
module tb_sequential_multiplier_integrated;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signedMode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic           accessError;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*N-1:0] prev_prod;
  logic [2*N-1:0] exp_prod;

  sequential_multiplier_integrated #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .signedMode(signedMode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product),
    .accessError(accessError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic sm);
    int sx, sy;
    sx = (sm && x[N-1]) ? int'(x) - (1 << N) : int'(x);
    sy = (sm && y[N-1]) ? int'(y) - (1 << N) : int'(y);
    return (2*N)'(sx * sy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
    a          = x;
    b          = y;
    signedMode = sm;
    start      = 1'b1;
    exp_prod   = model(x, y, sm);
  endtask

  // Runs from acceptance edge E0 through E_N; err_at>0 pulses start during RUN.
  task automatic finish_run(input int err_at);
    tick();
    start      = 1'b0;
    a          = N'($urandom);
    b          = N'($urandom);
    signedMode = 1'($urandom);
    check("e0_busy", busy, 1);
    check("e0_done", done, 0);
    check("e0_err", accessError, 0);
    for (int i = 1; i <= N; i++) begin
      tick();
      check("err", accessError, (err_at > 0 && i == err_at + 1) ? 1 : 0);
      if (i < N) begin
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("prod_hold", product, prev_prod);
      end else begin
        check("busy_end", busy, 0);
        check("done", done, 1);
        check("product", product, exp_prod);
      end
      start = 1'b0;
      if (err_at > 0 && i == err_at) begin
        start = 1'b1;
        a     = N'($urandom);
        b     = N'($urandom);
      end
    end
    prev_prod = exp_prod;
  endtask

  task automatic one(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
    launch(x, y, sm);
    finish_run(0);
    tick();
    check("done_pulse", done, 0);
    check("prod_after", product, prev_prod);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signedMode = 1'b0; a = '0; b = '0;
    prev_prod = '0; exp_prod = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", accessError, 0);
      check("rst_prod", product, 0);
    end

    one(8'd3, 8'd5, 1'b1);
    check("3x5", prev_prod, 16'h000F);
    one(8'h80, 8'h80, 1'b1); check("s80x80", prev_prod, 16'h4000);
    one(8'hFF, 8'h02, 1'b1); check("sFFx02", prev_prod, 16'hFFFE);
    one(8'h80, 8'h7F, 1'b1); check("s80x7F", prev_prod, 16'hC080);
    one(8'h00, 8'h80, 1'b1); check("s00x80", prev_prod, 16'h0000);
    one(8'hFF, 8'hFF, 1'b0); check("uFFxFF", prev_prod, 16'hFE01);
    one(8'h80, 8'h02, 1'b0); check("u80x02", prev_prod, 16'h0100);
    one(8'hFF, 8'hFF, 1'b1); check("sFFxFF", prev_prod, 16'h0001);
    one(8'h80, 8'h02, 1'b1); check("s80x02", prev_prod, 16'hFF00);

    // start while busy at RUN cycle 3
    launch(8'd11, 8'd13, 1'b0);
    finish_run(3);
    check("busy_err_result", prev_prod, 16'd143);

    // back-to-back: second start issued in the done cycle
    launch(8'd7, 8'd6, 1'b0);
    finish_run(0);
    check("b2b_result", prev_prod, 16'h002A);

    // reset mid-operation at RUN cycle 4
    tick();
    launch(8'd100, 8'd77, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_prod", product, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_done_after_rst", done, 0);
    end
    prev_prod = '0;
    one(8'd2, 8'd3, 1'b1);
    check("2x3", prev_prod, 16'h0006);

    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check("idle_done", done, 0);
        check("idle_prod", product, prev_prod);
      end
      launch(N'($urandom), N'($urandom), 1'($urandom));
      finish_run(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 2)) : 0);
    end
    tick();
    check("final_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
